// File: rtl/lvds_7to1_tx_serializer.sv
// 7:1 LVDS transmit serializer: pixel handshake in, 4 serial data lanes plus forwarded clock lane out.
// Optional PRBS7 lane test mode is compiled in when LVDS_TX_PRBS_EN is defined.
module lvds_7to1_tx_serializer #(
  parameter int         MAP_JEIDA   = 0,
  parameter logic [6:0] CLK_PATTERN = 7'b1100011
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [7:0] I_pix_r,
  input  logic [7:0] I_pix_g,
  input  logic [7:0] I_pix_b,
  input  logic       I_pix_hs,
  input  logic       I_pix_vs,
  input  logic       I_pix_de,
  input  logic       I_pix_valid,
  output logic       O_pix_ready,
  input  logic       I_underflow_clr,
  output logic       O_underflow,
  output logic       O_lvds_tx_clk,
  output logic       O_lvds_tx_d0,
  output logic       O_lvds_tx_d1,
  output logic       O_lvds_tx_d2,
  output logic       O_lvds_tx_d3
`ifdef LVDS_TX_PRBS_EN
  ,
  input  logic       I_prbs_mode
`endif
);

  logic [2:0] ph;
  logic       load;
  logic       accept;
  logic       prbs;
  logic       armed;
  logic       hs_q, vs_q;
  logic       underflow;
  logic [6:0] sh_clk, sh_d0, sh_d1, sh_d2, sh_d3;
  logic [7:0] r, g, b;
  logic       hs, vs, de;
  logic [6:0] w0, w1, w2, w3;

`ifdef LVDS_TX_PRBS_EN
  logic [6:0] lfsr;
  assign prbs = I_prbs_mode;
`else
  assign prbs = 1'b0;
`endif

  assign load        = (ph == 3'd6);
  assign O_pix_ready = load & ~I_rst & ~prbs;
  assign accept      = O_pix_ready & I_pix_valid;

  // Blanking word: no colour, DE low, syncs held from the last accepted pixel
  always_comb begin
    r  = '0;
    g  = '0;
    b  = '0;
    hs = hs_q;
    vs = vs_q;
    de = 1'b0;
    if (accept) begin
      r  = I_pix_r;
      g  = I_pix_g;
      b  = I_pix_b;
      hs = I_pix_hs;
      vs = I_pix_vs;
      de = I_pix_de;
    end
  end

  always_comb begin
    if (MAP_JEIDA != 0) begin
      w0 = {g[2], r[7:2]};
      w1 = {b[3:2], g[7:3]};
      w2 = {de, vs, hs, b[7:4]};
      w3 = {1'b0, b[1:0], g[1:0], r[1:0]};
    end else begin
      w0 = {g[0], r[5:0]};
      w1 = {b[1:0], g[5:1]};
      w2 = {de, vs, hs, b[5:2]};
      w3 = {1'b0, b[7:6], g[7:6], r[7:6]};
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      ph        <= 3'd6;
      armed     <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      underflow <= 1'b0;
      sh_clk    <= '0;
      sh_d0     <= '0;
      sh_d1     <= '0;
      sh_d2     <= '0;
      sh_d3     <= '0;
    end else begin
      ph <= load ? 3'd0 : ph + 3'd1;
      if (load) begin
        sh_clk <= CLK_PATTERN;
        sh_d0  <= w0;
        sh_d1  <= w1;
        sh_d2  <= w2;
        sh_d3  <= w3;
      end else begin
        sh_clk <= {sh_clk[5:0], 1'b0};
        sh_d0  <= {sh_d0[5:0], 1'b0};
        sh_d1  <= {sh_d1[5:0], 1'b0};
        sh_d2  <= {sh_d2[5:0], 1'b0};
        sh_d3  <= {sh_d3[5:0], 1'b0};
      end
      if (accept) begin
        armed <= 1'b1;
        hs_q  <= I_pix_hs;
        vs_q  <= I_pix_vs;
      end
      // Set takes priority over clear when both land in the same cycle
      if (!prbs) begin
        if (load && !accept && armed)
          underflow <= 1'b1;
        else if (I_underflow_clr)
          underflow <= 1'b0;
      end
    end
  end

  assign O_underflow   = underflow;
  assign O_lvds_tx_clk = sh_clk[6];

`ifdef LVDS_TX_PRBS_EN
  always_ff @(posedge I_clk) begin
    if (I_rst)
      lfsr <= 7'h7F;
    else if (I_prbs_mode)
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  assign O_lvds_tx_d0 = prbs ? lfsr[0] : sh_d0[6];
  assign O_lvds_tx_d1 = prbs ? lfsr[1] : sh_d1[6];
  assign O_lvds_tx_d2 = prbs ? lfsr[2] : sh_d2[6];
  assign O_lvds_tx_d3 = prbs ? lfsr[3] : sh_d3[6];
`else
  assign O_lvds_tx_d0 = sh_d0[6];
  assign O_lvds_tx_d1 = sh_d1[6];
  assign O_lvds_tx_d2 = sh_d2[6];
  assign O_lvds_tx_d3 = sh_d3[6];
`endif

endmodule

// File: tb/tb_lvds_7to1_tx_serializer.sv
// Directed bench for lvds_7to1_tx_serializer: VESA and JEIDA instances share one stimulus stream.
module tb_lvds_7to1_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] r, g, b;
  logic       hs, vs, de, valid, clr;
  logic       ready, uf, lclk, d0, d1, d2, d3;
  logic       j_ready, j_uf, j_clk, j_d0, j_d1, j_d2, j_d3;

  logic [6:0] w0, w1, w2, w3, wc, wr;
  logic [6:0] wj0, wj1, wj2, wj3, wjc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lvds_7to1_tx_serializer #(.MAP_JEIDA(0), .CLK_PATTERN(7'b1100011)) u_vesa (
    .I_clk(clk), .I_rst(rst), .I_pix_r(r), .I_pix_g(g), .I_pix_b(b),
    .I_pix_hs(hs), .I_pix_vs(vs), .I_pix_de(de), .I_pix_valid(valid),
    .O_pix_ready(ready), .I_underflow_clr(clr), .O_underflow(uf),
    .O_lvds_tx_clk(lclk), .O_lvds_tx_d0(d0), .O_lvds_tx_d1(d1),
    .O_lvds_tx_d2(d2), .O_lvds_tx_d3(d3)
  );

  lvds_7to1_tx_serializer #(.MAP_JEIDA(1), .CLK_PATTERN(7'b1100011)) u_jeida (
    .I_clk(clk), .I_rst(rst), .I_pix_r(r), .I_pix_g(g), .I_pix_b(b),
    .I_pix_hs(hs), .I_pix_vs(vs), .I_pix_de(de), .I_pix_valid(valid),
    .O_pix_ready(j_ready), .I_underflow_clr(clr), .O_underflow(j_uf),
    .O_lvds_tx_clk(j_clk), .O_lvds_tx_d0(j_d0), .O_lvds_tx_d1(j_d1),
    .O_lvds_tx_d2(j_d2), .O_lvds_tx_d3(j_d3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a load edge; collects the 7 serial bits and returns at the next load slot
  task automatic capture();
    for (int i = 6; i >= 0; i--) begin
      w0[i] = d0;   w1[i] = d1;   w2[i] = d2;   w3[i] = d3;   wc[i] = lclk; wr[i] = ready;
      wj0[i] = j_d0; wj1[i] = j_d1; wj2[i] = j_d2; wj3[i] = j_d3; wjc[i] = j_clk;
      if (i > 0) tick();
    end
  endtask

  function automatic logic [27:0] vesa_words(input logic [7:0] pr, pg, pb, input logic phs, pvs, pde);
    logic [6:0] a0, a1, a2, a3;
    a0 = {pg[0], pr[5], pr[4], pr[3], pr[2], pr[1], pr[0]};
    a1 = {pb[1], pb[0], pg[5], pg[4], pg[3], pg[2], pg[1]};
    a2 = {pde, pvs, phs, pb[5], pb[4], pb[3], pb[2]};
    a3 = {1'b0, pb[7], pb[6], pg[7], pg[6], pr[7], pr[6]};
    return {a3, a2, a1, a0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if ({lclk, d3, d2, d1, d0} !== 5'b0) begin miscompares++; $display("FAIL reset_lanes got %b want 00000", {lclk, d3, d2, d1, d0}); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b want 0", uf); end
    rst = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL release_ready got %b want 1", ready); end
    tick();
    capture();
    vectors++; if (wc !== 7'b1100011) begin miscompares++; $display("FAIL first_clk_word got %b want 1100011", wc); end
    vectors++; if ({w3, w2, w1, w0} !== 28'h0) begin miscompares++; $display("FAIL first_blank_word got %h want 0", {w3, w2, w1, w0}); end
    vectors++; if (wr !== 7'b0000001) begin miscompares++; $display("FAIL ready_cadence got %b want 0000001", wr); end
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL unarmed_underflow got %b want 0", uf); end
  endtask

  task automatic test_vesa_pixel();
    r = 8'hFF; g = 8'h00; b = 8'h00; hs = 1'b0; vs = 1'b0; de = 1'b1; valid = 1'b1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL vesa_ready got %b want 1", ready); end
    tick();
    valid = 1'b0; r = 8'h5A; g = 8'hC3; b = 8'h99; de = 1'b0;
    capture();
    vectors++; if (w0 !== 7'b0111111) begin miscompares++; $display("FAIL vesa_d0 got %b want 0111111", w0); end
    vectors++; if (w1 !== 7'b0000000) begin miscompares++; $display("FAIL vesa_d1 got %b want 0000000", w1); end
    vectors++; if (w2 !== 7'b1000000) begin miscompares++; $display("FAIL vesa_d2 got %b want 1000000", w2); end
    vectors++; if (w3 !== 7'b0000011) begin miscompares++; $display("FAIL vesa_d3 got %b want 0000011", w3); end
    vectors++; if (wc !== 7'b1100011) begin miscompares++; $display("FAIL vesa_clk got %b want 1100011", wc); end
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL vesa_underflow got %b want 0", uf); end
  endtask

  task automatic test_underflow();
    r = 8'h12; g = 8'h34; b = 8'h56; hs = 1'b1; vs = 1'b0; de = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0; hs = 1'b0;
    capture();
    vectors++; if (w2 !== 7'b1010101) begin miscompares++; $display("FAIL hs_pixel_d2 got %b want 1010101", w2); end
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL pre_blank_underflow got %b want 0", uf); end
    tick();
    vectors++; if (uf !== 1'b1) begin miscompares++; $display("FAIL blank_sets_underflow got %b want 1", uf); end
    capture();
    vectors++; if (w2 !== 7'b0010000) begin miscompares++; $display("FAIL blank_d2_hs_held got %b want 0010000", w2); end
    vectors++; if ({w3, w1, w0} !== 21'h0) begin miscompares++; $display("FAIL blank_other_lanes got %h want 0", {w3, w1, w0}); end
    vectors++; if (uf !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %b want 1", uf); end
    clr = 1'b1;
    tick();
    vectors++; if (uf !== 1'b1) begin miscompares++; $display("FAIL set_wins_over_clear got %b want 1", uf); end
    clr = 1'b0;
    tick();
    vectors++; if (uf !== 1'b1) begin miscompares++; $display("FAIL underflow_held got %b want 1", uf); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL underflow_clear got %b want 0", uf); end
    repeat (4) tick();
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL realign_ready got %b want 1", ready); end
  endtask

  task automatic test_stream();
    logic [27:0] exp;
    for (int i = 0; i < 100; i++) begin
      r = 8'(i * 37 + 5); g = 8'(i * 11); b = 8'(255 - i);
      hs = 1'(i & 1); vs = 1'((i >> 1) & 1); de = (i % 3) != 0; valid = 1'b1;
      exp = vesa_words(r, g, b, hs, vs, de);
      vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d] got %b want 1", i, ready); end
      tick();
      capture();
      vectors++; if ({w3, w2, w1, w0} !== exp) begin miscompares++; $display("FAIL stream_word[%0d] got %h want %h", i, {w3, w2, w1, w0}, exp); end
      vectors++; if (wc !== 7'b1100011) begin miscompares++; $display("FAIL stream_clk[%0d] got %b want 1100011", i, wc); end
      vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL stream_underflow[%0d] got %b want 0", i, uf); end
    end
    valid = 1'b0;
  endtask

  task automatic test_blank_hold();
    tick();
    capture();
    vectors++; if (w2 !== 7'b0110000) begin miscompares++; $display("FAIL hold_hsvs_d2 got %b want 0110000", w2); end
    vectors++; if ({w3, w1, w0} !== 21'h0) begin miscompares++; $display("FAIL hold_other_lanes got %h want 0", {w3, w1, w0}); end
    vectors++; if (uf !== 1'b1) begin miscompares++; $display("FAIL stream_end_underflow got %b want 1", uf); end
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL hold_clear got %b want 0", uf); end
    repeat (5) tick();
  endtask

  task automatic test_jeida();
    r = 8'h03; g = 8'h00; b = 8'h00; hs = 1'b0; vs = 1'b0; de = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    capture();
    vectors++; if (wj3 !== 7'b0000011) begin miscompares++; $display("FAIL jeida_r03_d3 got %b want 0000011", wj3); end
    vectors++; if (wj0 !== 7'b0000000) begin miscompares++; $display("FAIL jeida_r03_d0 got %b want 0000000", wj0); end
    vectors++; if ({w3, w0} !== 14'b0000000_0000011) begin miscompares++; $display("FAIL vesa_r03_d3d0 got %b want 00000000000011", {w3, w0}); end
    r = 8'h00; g = 8'h84; b = 8'h0F; hs = 1'b0; vs = 1'b1; de = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    capture();
    vectors++; if ({wj3, wj2, wj1, wj0} !== {7'b0110000, 7'b1100000, 7'b1110000, 7'b1000000}) begin miscompares++; $display("FAIL jeida_mix got %b want 0110000110000011100001000000", {wj3, wj2, wj1, wj0}); end
    vectors++; if ({w3, w2, w1, w0} !== {7'b0001000, 7'b1100011, 7'b1100010, 7'b0000000}) begin miscompares++; $display("FAIL vesa_mix got %b want 0001000110001111000100000000", {w3, w2, w1, w0}); end
    vectors++; if (wjc !== 7'b1100011) begin miscompares++; $display("FAIL jeida_clk got %b want 1100011", wjc); end
  endtask

  task automatic test_reset_mid();
    r = 8'hFF; g = 8'h00; b = 8'h00; hs = 1'b1; vs = 1'b1; de = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    vectors++; if (d0 !== 1'b1) begin miscompares++; $display("FAIL mid_word_d0 got %b want 1", d0); end
    rst = 1'b1;
    #1;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ready got %b want 0", ready); end
    tick();
    vectors++; if ({lclk, d3, d2, d1, d0, j_clk, j_d3, j_d2, j_d1, j_d0} !== 10'b0) begin miscompares++; $display("FAIL mid_reset_lanes got %b want 0000000000", {lclk, d3, d2, d1, d0, j_clk, j_d3, j_d2, j_d1, j_d0}); end
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL mid_reset_underflow got %b want 0", uf); end
    rst = 1'b0;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready got %b want 1", ready); end
    tick();
    capture();
    vectors++; if ({w3, w2, w1, w0} !== 28'h0) begin miscompares++; $display("FAIL post_reset_blank got %h want 0", {w3, w2, w1, w0}); end
    vectors++; if (wc !== 7'b1100011) begin miscompares++; $display("FAIL post_reset_clk got %b want 1100011", wc); end
    vectors++; if (uf !== 1'b0) begin miscompares++; $display("FAIL post_reset_disarmed got %b want 0", uf); end
  endtask

  initial begin
    rst = 1'b1; r = '0; g = '0; b = '0; hs = 1'b0; vs = 1'b0; de = 1'b0; valid = 1'b0; clr = 1'b0;
    test_reset();
    test_vesa_pixel();
    test_underflow();
    test_stream();
    test_blank_hold();
    test_jeida();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
